// File: rtl/reg_file_bank.sv
// reg_file_bank: two-read, one-write register file with a clear sweep after
// reset, same-cycle write bypass and an optional hardwired-zero register 0.
// Optional feature macro: REGFILE_SCOREBOARD_EN adds a per-register busy
// vector (set by a reserve strobe, cleared by a write) reported on
// rs_busy/rt_busy. Without it, those outputs are 0 and rsv/rsva are ignored.
//
// Handshake: there is no valid/ready pairing on writes; ready is a level that
// is high once the clear sweep has finished, and a write (cnt=1) or reserve
// (rsv=1) only takes effect on a rising edge while ready is high and rst is 0.
module reg_file_bank #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rsa,
  input  logic [AW-1:0]    rta,
  output logic [WIDTH-1:0] rsd,
  output logic [WIDTH-1:0] rtd,
  input  logic [AW-1:0]    wta,
  input  logic [WIDTH-1:0] wtd,
  input  logic             cnt,
  output logic             ready,
  input  logic             rsv,
  input  logic [AW-1:0]    rsva,
  output logic             rs_busy,
  output logic             rt_busy
);

  localparam bit ZR = (ZERO_REG != 0);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [WIDTH-1:0]  regs_d [DEPTH];
  logic              wr_en;
  logic              byp_s, byp_t;

  assign ready = (state_q == READY);

  // A write is effective only in READY, outside reset, and never to a hardwired-zero reg 0.
  assign wr_en = ready && !rst && cnt && !(ZR && (wta == '0));
  assign byp_s = wr_en && (rsa == wta);
  assign byp_t = wr_en && (rta == wta);

  // Next-state logic: sweep clr_ptr through every register, then settle in READY.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == AW'(DEPTH - 1)) state_d = READY;
      end
      READY: ;
      default: state_d = CLEAR;
    endcase
  end

  // State register with synchronous reset that restarts the sweep from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Storage update: the sweep zeroes one entry per cycle; otherwise apply an effective write.
  always_comb begin
    regs_d = regs_q;
    if (!rst && (state_q == CLEAR)) regs_d[clr_ptr_q] = '0;
    else if (wr_en)                 regs_d[wta]       = wtd;
  end

  // Storage flops; contents are defined by the sweep, so no reset is needed here.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  // Combinational reads with write bypass; outputs stay 0 until the sweep is done.
  always_comb begin
    rsd = '0;
    rtd = '0;
    if (ready) begin
      if (byp_s)                  rsd = wtd;
      else if (!(ZR && rsa == '0)) rsd = regs_q[rsa];
      if (byp_t)                  rtd = wtd;
      else if (!(ZR && rta == '0)) rtd = regs_q[rta];
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             rsv_en;

  assign rsv_en = ready && !rst && rsv;

  // Busy update: a write clears its target, a reserve sets its target and wins a tie.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)  busy_d[wta]  = 1'b0;
    if (rsv_en) busy_d[rsva] = 1'b1;
    if (ZR)     busy_d[0]    = 1'b0;
  end

  // Busy flops, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Busy flags: a bypassed write reports not-busy unless a same-cycle reserve re-marks it.
  always_comb begin
    rs_busy = 1'b0;
    rt_busy = 1'b0;
    if (ready) begin
      if (byp_s) rs_busy = rsv_en && (rsva == rsa);
      else       rs_busy = busy_q[rsa];
      if (byp_t) rt_busy = rsv_en && (rsva == rta);
      else       rt_busy = busy_q[rta];
    end
  end
`else
  logic unused_rsv;
  assign unused_rsv = ^{rsv, rsva};
  assign rs_busy    = 1'b0;
  assign rt_busy    = 1'b0;
`endif

endmodule

// File: tb/tb_reg_file_bank.sv
// tb_reg_file_bank: scoreboard bench for reg_file_bank with WIDTH=32, DEPTH=32,
// ZERO_REG=1. Busy-flag behaviour is checked against the build of
// REGFILE_SCOREBOARD_EN the bench is compiled with.
module tb_reg_file_bank;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rsa, rta, wta, rsva;
  logic [W-1:0]  rsd, rtd, wtd;
  logic          cnt, ready, rsv, rs_busy, rt_busy;

  logic [W-1:0]  exp_q [$];
  int            sel_q [$];
  string         tag_q [$];
  logic [W-1:0]  mem [D];

  int checks;
  int errors;

  reg_file_bank #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rsa(rsa), .rta(rta), .rsd(rsd), .rtd(rtd),
    .wta(wta), .wtd(wtd), .cnt(cnt), .ready(ready), .rsv(rsv), .rsva(rsva),
    .rs_busy(rs_busy), .rt_busy(rt_busy)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sel: 0 rsd, 1 rtd, 2 ready, 3 rs_busy, 4 rt_busy
  task automatic expect_out(input string tag, input int sel, input logic [W-1:0] exp);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    exp_q.push_back(exp);
  endtask

  // Compare all pending expectations at the falling edge, then advance past the rising edge.
  task automatic step();
    logic [W-1:0] obs;
    int           sel;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      sel = sel_q.pop_front();
      case (sel)
        0:       obs = rsd;
        1:       obs = rtd;
        2:       obs = W'(ready);
        3:       obs = W'(rs_busy);
        default: obs = W'(rt_busy);
      endcase
      check_eq(tag_q.pop_front(), obs, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cnt = 1'b0; rsv = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < D; i++) mem[i] = '0;
  endtask

  // Expect ready=0 with zero outputs for D cycles (cnt held high to prove it is ignored), then ready=1.
  task automatic sweep_checks(input string tag);
    for (int i = 0; i < D; i++) begin
      cnt = 1'b1; wta = AW'(i % (D - 1) + 1); wtd = $urandom();
      rsv = 1'b1; rsva = AW'(i);
      rsa = AW'(i); rta = AW'(D - 1 - i);
      expect_out({tag, "_ready"}, 2, 0);
      expect_out({tag, "_rsd"}, 0, 0);
      expect_out({tag, "_rtd"}, 1, 0);
      expect_out({tag, "_rsb"}, 3, 0);
      step();
    end
    idle();
    expect_out({tag, "_ready_hi"}, 2, 1);
    step();
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; cnt = 1'b0; rsv = 1'b0;
    rsa = '0; rta = '0; wta = '0; wtd = '0; rsva = '0;

    // Reset sweep with writes presented throughout
    do_reset();
    sweep_checks("sweep");

    // Every address reads 0 on both ports
    for (int i = 0; i < D; i++) begin
      rsa = AW'(i); rta = AW'(D - 1 - i);
      expect_out("clr_rsd", 0, 0);
      expect_out("clr_rtd", 1, 0);
      expect_out("clr_rsb", 3, 0);
      step();
    end

    // Write with bypass, then read from storage
    cnt = 1'b1; wta = 1; wtd = 1; rsa = 1; rta = 4;
    expect_out("wr_byp_rsd", 0, 1);
    expect_out("wr_byp_rtd", 1, 0);
    step(); mem[1] = 1;
    cnt = 1'b0;
    expect_out("wr_stor_rsd", 0, 1);
    step();

    // Dual bypass to the same address
    cnt = 1'b1; wta = 2; wtd = 10; rsa = 2; rta = 2;
    expect_out("dual_rsd", 0, 10);
    expect_out("dual_rtd", 1, 10);
    step(); mem[2] = 10;
    cnt = 1'b0;
    expect_out("dual_stor", 1, 10);
    step();

    // Register 0 stays zero
    cnt = 1'b1; wta = 0; wtd = 2; rsa = 0; rta = 0;
    expect_out("zero_byp_rsd", 0, 0);
    expect_out("zero_byp_rtd", 1, 0);
    step();
    cnt = 1'b0;
    expect_out("zero_rsd", 0, 0);
    expect_out("zero_rtd", 1, 0);
    step();

`ifdef REGFILE_SCOREBOARD_EN
    // Reserve, observe busy, clear by write, then set-wins tie
    rsv = 1'b1; rsva = 3; rsa = 3; rta = 3;
    expect_out("rsv_same_cyc", 3, 0);
    step();
    rsv = 1'b0;
    expect_out("rsv_rs_busy", 3, 1);
    expect_out("rsv_rt_busy", 4, 1);
    step();
    cnt = 1'b1; wta = 3; wtd = 33;
    expect_out("clr_byp_busy", 3, 0);
    step(); mem[3] = 33;
    cnt = 1'b0;
    expect_out("clr_busy", 3, 0);
    step();
    rsv = 1'b1; rsva = 3; cnt = 1'b1; wta = 3; wtd = 34; rsa = 5; rta = 5;
    step(); mem[3] = 34;
    idle(); rsa = 3;
    expect_out("tie_busy", 3, 1);
    expect_out("tie_data", 0, 34);
    step();
    rsv = 1'b1; rsva = 0; rsa = 0;
    step();
    rsv = 1'b0;
    expect_out("zero_busy", 3, 0);
    step();
    cnt = 1'b1; wta = 3; wtd = 35;
    step(); mem[3] = 35;
    cnt = 1'b0;
`else
    // Reserve has no effect when the busy vector is compiled out
    rsv = 1'b1; rsva = 3; rsa = 3; rta = 3;
    step();
    rsv = 1'b0;
    expect_out("nosb_rs_busy", 3, 0);
    expect_out("nosb_rt_busy", 4, 0);
    step();
`endif

    // Random traffic on a small address window to force collisions
    for (int n = 0; n < 300; n++) begin
      logic         we;
      logic [W-1:0] es, et;
      cnt = 1'($urandom_range(0, 1));
      wta = AW'($urandom_range(0, 7));
      wtd = $urandom();
      rsa = AW'($urandom_range(0, 7));
      rta = AW'($urandom_range(0, 7));
      we  = cnt && (wta != 0);
      es  = (we && rsa == wta) ? wtd : mem[rsa];
      et  = (we && rta == wta) ? wtd : mem[rta];
      expect_out("rnd_rsd", 0, es);
      expect_out("rnd_rtd", 1, et);
      step();
      if (we) mem[wta] = wtd;
    end
    idle();

    // Reset edge with a write presented, then restart the sweep at cycle 10
    cnt = 1'b1; wta = 5; wtd = 32'h5a5a;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      expect_out("mid_ready", 2, 0);
      step();
    end
    do_reset();
    sweep_checks("resweep");
    rsa = 1; rta = 5;
    expect_out("post_rst_rsd", 0, 0);
    expect_out("post_rst_rtd", 1, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
